// File: rtl/timer_prescaler_ctrl_pkg.sv
// timer_prescaler_ctrl_pkg: division mode encodings and terminal-count decode helper.
package timer_prescaler_ctrl_pkg;
  localparam logic DIV_MODE_POW2 = 1'b0;
  localparam logic DIV_MODE_LIN = 1'b1;
  localparam int TERM_W = 16;
  function automatic logic [TERM_W-1:0] calc_term(input logic div_en, input logic div_mode,
                                                  input logic [TERM_W-1:0] div_val, input int pre_w);
    logic [TERM_W-1:0] full, pw;
    full = TERM_W'((32'd1 << pre_w) - 32'd1);
    pw = TERM_W'((32'd1 << div_val) - 32'd1);
    calc_term = !div_en ? '0 :
                div_mode == DIV_MODE_LIN ? (div_val > full ? full : div_val) :
                (int'(div_val) > pre_w ? full : pw);
  endfunction
endpackage

// File: rtl/timer_prescaler_ctrl_if.sv
// timer_prescaler_ctrl_if: control, debug-halt and status signals of the prescaler.
interface timer_prescaler_ctrl_if #(
  parameter int PRE_W = 8,
  parameter int DIV_W = 4
);
  logic timer_en;
  logic div_en;
  logic div_mode;
  logic [DIV_W-1:0] div_val;
  logic debug_mode;
  logic halt_req;
  logic halt_ack;
  logic cnt_en;
  logic cnt_clr;
  logic [PRE_W-1:0] pre_cnt;
  logic cfg_err;
  modport master (
    output timer_en, div_en, div_mode, div_val, debug_mode, halt_req,
    input halt_ack, cnt_en, cnt_clr, pre_cnt, cfg_err
  );
  modport slave (
    input timer_en, div_en, div_mode, div_val, debug_mode, halt_req,
    output halt_ack, cnt_en, cnt_clr, pre_cnt, cfg_err
  );
endinterface

// File: rtl/timer_prescaler_ctrl_div_decode.sv
// timer_prescaler_ctrl_div_decode: combinational terminal count and pow2 saturation flag.
module timer_prescaler_ctrl_div_decode
  import timer_prescaler_ctrl_pkg::*;
#(
  parameter int PRE_W = 8,
  parameter int DIV_W = 4
) (
  input  logic              div_en,
  input  logic              div_mode,
  input  logic [DIV_W-1:0]  div_val,
  output logic [TERM_W-1:0] term,
  output logic              sat
);
  always_comb begin
    term = calc_term(div_en, div_mode, TERM_W'(div_val), PRE_W);
    sat = div_en & (div_mode == DIV_MODE_POW2) & (int'(div_val) > PRE_W);
  end
endmodule

// File: rtl/timer_prescaler_ctrl.sv
// timer_prescaler_ctrl: prescaler emitting a 1-cycle cnt_en every T+1 enabled cycles,
// with config-change restart, registered debug halt and timer_en falling-edge clear pulse.
module timer_prescaler_ctrl
  import timer_prescaler_ctrl_pkg::*;
#(
  parameter int PRE_W = 8,
  parameter int DIV_W = 4
) (
  input logic sys_clk,
  input logic sys_rst_n,
  timer_prescaler_ctrl_if.slave bus
);
  logic [TERM_W-1:0] term;
  logic sat, cfg_chg, at_term, timer_en_q;
  logic [DIV_W+1:0] cfg, shadow;
  logic [PRE_W-1:0] pre_nxt;
  timer_prescaler_ctrl_div_decode #(.PRE_W(PRE_W), .DIV_W(DIV_W)) u_dec (
    .div_en(bus.div_en),
    .div_mode(bus.div_mode),
    .div_val(bus.div_val),
    .term(term),
    .sat(sat)
  );
  always_comb begin
    cfg = {bus.div_en, bus.div_mode, bus.div_val};
    cfg_chg = cfg != shadow;
    at_term = TERM_W'(bus.pre_cnt) == term;
    // restart beats halt so a config written during a debug halt takes effect at once
    pre_nxt = !bus.timer_en ? '0 :
              cfg_chg ? '0 :
              bus.halt_ack ? bus.pre_cnt :
              at_term ? '0 : bus.pre_cnt + PRE_W'(1);
    bus.cnt_en = bus.timer_en & ~bus.halt_ack & ~cfg_chg & at_term;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bus.pre_cnt <= '0;
      bus.halt_ack <= 1'b0;
      bus.cnt_clr <= 1'b0;
      bus.cfg_err <= 1'b0;
      shadow <= '0;
      timer_en_q <= 1'b0;
    end else begin
      bus.pre_cnt <= pre_nxt;
      bus.halt_ack <= bus.debug_mode & bus.halt_req;
      bus.cnt_clr <= timer_en_q & ~bus.timer_en;
      bus.cfg_err <= sat;
      shadow <= cfg;
      timer_en_q <= bus.timer_en;
    end
  end
endmodule

// File: tb/tb_timer_prescaler_ctrl.sv
// tb_timer_prescaler_ctrl: directed scenarios plus randomized traffic checked cycle by cycle
// against an arithmetic reference of the prescaler rules.
module tb_timer_prescaler_ctrl;
  localparam int PRE_W = 8;
  localparam int DIV_W = 4;
  localparam int MAX_T = (1 << PRE_W) - 1;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  int m_cnt;
  bit m_ack, m_clr, m_err, m_ten_q, m_en_p, m_mode_p;
  int m_val_p;
  bit obs_en;
  timer_prescaler_ctrl_if #(.PRE_W(PRE_W), .DIV_W(DIV_W)) bus ();
  timer_prescaler_ctrl #(.PRE_W(PRE_W), .DIV_W(DIV_W)) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus.slave)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic int term_of(bit en, bit mode, int val);
    if (!en) return 0;
    if (mode) return val < MAX_T ? val : MAX_T;
    return (1 << (val > PRE_W ? PRE_W : val)) - 1;
  endfunction
  task automatic set_cfg(input bit e, input bit m, input int v);
    bus.div_en = e;
    bus.div_mode = m;
    bus.div_val = DIV_W'(v);
  endtask
  task automatic model_clear();
    m_cnt = 0;
    m_ack = 0;
    m_clr = 0;
    m_err = 0;
    m_ten_q = 0;
    m_en_p = 0;
    m_mode_p = 0;
    m_val_p = 0;
  endtask
  task automatic step();
    bit chg, exp_en;
    int t;
    #1;
    t = term_of(bus.div_en, bus.div_mode, int'(bus.div_val));
    chg = (bus.div_en != m_en_p) || (bus.div_mode != m_mode_p) || (int'(bus.div_val) != m_val_p);
    exp_en = bus.timer_en && !m_ack && !chg && (m_cnt == t);
    check("pre_cnt", int'(bus.pre_cnt), m_cnt);
    check("halt_ack", int'(bus.halt_ack), int'(m_ack));
    check("cnt_clr", int'(bus.cnt_clr), int'(m_clr));
    check("cfg_err", int'(bus.cfg_err), int'(m_err));
    check("cnt_en", int'(bus.cnt_en), int'(exp_en));
    obs_en = bus.cnt_en;
    @(posedge sys_clk);
    m_cnt = !bus.timer_en ? 0 : chg ? 0 : m_ack ? m_cnt : (m_cnt == t) ? 0 : m_cnt + 1;
    m_ack = bus.debug_mode && bus.halt_req;
    m_clr = m_ten_q && !bus.timer_en;
    m_ten_q = bus.timer_en;
    m_err = bus.div_en && !bus.div_mode && int'(bus.div_val) > PRE_W;
    m_en_p = bus.div_en;
    m_mode_p = bus.div_mode;
    m_val_p = int'(bus.div_val);
    @(negedge sys_clk);
  endtask
  task automatic do_reset();
    sys_rst_n = 1'b0;
    #2;
    check("rst_pre_cnt", int'(bus.pre_cnt), 0);
    check("rst_halt_ack", int'(bus.halt_ack), 0);
    check("rst_cnt_clr", int'(bus.cnt_clr), 0);
    check("rst_cfg_err", int'(bus.cfg_err), 0);
    check("rst_cnt_en", int'(bus.cnt_en), 0);
    model_clear();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask
  task automatic run_to(input int target, input string tag);
    int k = 0;
    while (m_cnt != target && k < 600) begin
      step();
      k++;
    end
    check(tag, m_cnt, target);
  endtask
  task automatic count_to_tick(input int exp, input string tag);
    int k = 0;
    obs_en = 0;
    while (!obs_en && k < 600) begin
      step();
      k++;
    end
    check(tag, k, exp);
  endtask
  initial begin
    bus.timer_en = 0;
    bus.debug_mode = 0;
    bus.halt_req = 0;
    set_cfg(0, 0, 0);
    do_reset();
    bus.timer_en = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_tick", int'(obs_en), 1);
      check("t1_pre", int'(bus.pre_cnt), 0);
    end
    bus.timer_en = 0;
    set_cfg(1, 0, 3);
    repeat (2) step();
    bus.timer_en = 1;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("t2_tick", int'(obs_en), int'(k % 8 == 0));
    end
    bus.timer_en = 0;
    set_cfg(1, 1, 4);
    repeat (2) step();
    bus.timer_en = 1;
    run_to(3, "t3_reach");
    set_cfg(1, 1, 2);
    step();
    check("t3_chg_tick", int'(obs_en), 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("t3_tick", int'(obs_en), int'(k == 3));
    end
    bus.timer_en = 0;
    set_cfg(1, 1, 9);
    repeat (2) step();
    bus.timer_en = 1;
    run_to(5, "t4_reach");
    bus.debug_mode = 1;
    bus.halt_req = 1;
    repeat (5) step();
    check("t4_ack", int'(bus.halt_ack), 1);
    check("t4_hold", int'(bus.pre_cnt), 6);
    bus.halt_req = 0;
    step();
    check("t4_ack_lag", int'(bus.halt_ack), 0);
    check("t4_hold_end", int'(bus.pre_cnt), 6);
    count_to_tick(4, "t4_resume");
    bus.debug_mode = 0;
    bus.timer_en = 0;
    set_cfg(1, 0, 12);
    step();
    check("t5_err", int'(bus.cfg_err), 1);
    bus.timer_en = 1;
    count_to_tick(256, "t5_period");
    bus.timer_en = 0;
    step();
    check("t5_clr", int'(bus.cnt_clr), 1);
    check("t5_pre", int'(bus.pre_cnt), 0);
    step();
    check("t5_clr_end", int'(bus.cnt_clr), 0);
    set_cfg(1, 0, 8);
    step();
    bus.timer_en = 1;
    run_to(100, "t6_reach");
    do_reset();
    bus.timer_en = 0;
    step();
    bus.timer_en = 1;
    count_to_tick(256, "t6_first");
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(99) == 0) bus.timer_en = ~bus.timer_en;
      if ($urandom_range(59) == 0)
        set_cfg(1'($urandom_range(4) != 0), 1'($urandom_range(1)), int'($urandom_range(15)));
      if ($urandom_range(39) == 0) bus.debug_mode = ~bus.debug_mode;
      if ($urandom_range(14) == 0) bus.halt_req = ~bus.halt_req;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
